// File: rtl/mips_cpu_bus_lsu.sv
// Load/store unit: one CPU byte/half/word request becomes one word-aligned bus transfer.
// Latency: store 2, load 3, misaligned 1 cycle(s) + 1 per stalled bus edge; one request in flight.
module mips_cpu_bus_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [31:0]       writedata,
  input  logic              waitrequest,
  input  logic [31:0]       readdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RDATA, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              write_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic              misalign;
  logic [3:0]        be_in;
  logic [31:0]       wd_in;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;

  // size 11 is never legal, so it is folded into the misaligned case
  always_comb begin
    misalign = (req_size == 2'b11) ||
               (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  end

  always_comb begin
    be_in = 4'b1111;
    wd_in = req_wdata;
    case (req_size)
      2'b00: begin
        be_in = 4'b0001 << req_addr[1:0];
        wd_in = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_in = req_addr[1] ? 4'b1100 : 4'b0011;
        wd_in = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = readdata[7:0];
    case (addr_q[1:0])
      2'b01:   ld_byte = readdata[15:8];
      2'b10:   ld_byte = readdata[23:16];
      2'b11:   ld_byte = readdata[31:24];
      default: ;
    endcase
    ld_half = addr_q[1] ? readdata[31:16] : readdata[15:0];
    case (size_q)
      2'b00:   ld_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{signed_q & ld_half[15]}}, ld_half};
      default: ld_data = readdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = misalign ? S_RESP : S_BUS;
      S_BUS:   if (!waitrequest) state_d = write_q ? S_RESP : S_RDATA;
      S_RDATA: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      be_q     <= 4'b0000;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_valid) begin
        write_q  <= req_write;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        be_q     <= misalign ? 4'b0000 : be_in;
        wdata_q  <= wd_in;
        err_q    <= misalign;
        rdata_q  <= 32'h0;
      end
      if (state_q == S_RDATA) rdata_q <= ld_data;
    end
  end

  // ready is gated by reset so it reads 0 for the whole time reset is held
  assign req_ready  = reset_n && (state_q == S_IDLE);
  assign address    = {addr_q[ADDR_W-1:2], 2'b00};
  assign read       = (state_q == S_BUS) && !write_q;
  assign write      = (state_q == S_BUS) && write_q;
  assign byteenable = be_q;
  assign writedata  = wdata_q;
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mips_cpu_bus_lsu.sv
// Directed bench for mips_cpu_bus_lsu: vector table of requests plus reset sequences.
module tb_mips_cpu_bus_lsu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] address;
  logic        read, write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_cpu_bus_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wt;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  // called at a falling edge; returns at the falling edge after the response cycle
  task automatic run_vec(input vec_t v, input int idx);
    int bus_n;
    int lat;
    logic [31:0] exp_addr;
    exp_addr = v.addr & 32'hFFFF_FFFC;
    chk($sformatf("v%0d_ready", idx), {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_size   = v.sz;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    readdata   = v.rdata;
    waitrequest = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    bus_n = 0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk($sformatf("v%0d_c%0d_rw_excl", idx, c), {31'b0, read & write}, 32'd0);
      waitrequest = 1'b0;
      if (read || write) begin
        chk($sformatf("v%0d_c%0d_dir", idx, c), {31'b0, write}, {31'b0, v.wr});
        chk($sformatf("v%0d_c%0d_addr", idx, c), address, exp_addr);
        chk($sformatf("v%0d_c%0d_be", idx, c), {28'b0, byteenable}, {28'b0, v.exp_be});
        if (v.wr) chk($sformatf("v%0d_c%0d_wd", idx, c), writedata, v.exp_wd);
        waitrequest = (bus_n < v.wt);
        bus_n++;
      end
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL v%0d_timeout: no resp_valid within 20 cycles", idx);
    end else begin
      chk($sformatf("v%0d_lat", idx), lat, v.exp_lat);
      chk($sformatf("v%0d_err", idx), {31'b0, resp_err}, {31'b0, v.exp_err});
      chk($sformatf("v%0d_rdata", idx), resp_rdata, v.exp_rd);
    end
    chk($sformatf("v%0d_strobes", idx), bus_n, v.exp_err ? 0 : v.wt + 1);
    @(negedge clk);
    chk($sformatf("v%0d_pulse1", idx), {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          wr   sz     sgn  addr      wdata         rdata         wt be       exp_wd        exp_rd        err  lat
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0, 2};
    vecs[1]  = '{1'b1, 2'b00, 1'b0, 32'h13, 32'h123456A5, 32'h0,        0, 4'b1000, 32'hA5A5A5A5, 32'h0,        1'b0, 2};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'hA5000000, 0, 4'b1000, 32'h0,        32'hFFFFFFA5, 1'b0, 3};
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'hA5000000, 0, 4'b1000, 32'h0,        32'h000000A5, 1'b0, 3};
    vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        32'h80017FFF, 0, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0, 3};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h22, 32'h0,        32'h80017FFF, 0, 4'b1100, 32'h0,        32'h00008001, 1'b0, 3};
    vecs[6]  = '{1'b0, 2'b10, 1'b1, 32'h30, 32'h0,        32'h12345678, 3, 4'b1111, 32'h0,        32'h12345678, 1'b0, 6};
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h0A, 32'h0,        32'h12345678, 0, 4'b0000, 32'h0,        32'h0,        1'b1, 1};
    vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h07, 32'hBEEF,     32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1, 1};
    vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h00, 32'h0,        32'hFFFFFFFF, 0, 4'b0000, 32'h0,        32'h0,        1'b1, 1};
    vecs[10] = '{1'b0, 2'b00, 1'b1, 32'h01, 32'h0,        32'h00007F00, 0, 4'b0010, 32'h0,        32'h0000007F, 1'b0, 3};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h06, 32'hFFFF1234, 32'h0,        1, 4'b1100, 32'h12341234, 32'h0,        1'b0, 3};
    vecs[12] = '{1'b0, 2'b00, 1'b0, 32'h02, 32'h0,        32'h00FE0000, 0, 4'b0100, 32'h0,        32'h000000FE, 1'b0, 3};

    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; waitrequest = 1'b0; readdata = 32'h0;
    #12;
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_read", {31'b0, read}, 32'd0);
    chk("rst_write", {31'b0, write}, 32'd0);
    chk("rst_be", {28'b0, byteenable}, 32'd0);
    chk("rst_addr", address, 32'd0);
    chk("rst_wd", writedata, 32'd0);
    chk("rst_resp", {30'b0, resp_valid, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("rel_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // reset while a stalled read is on the bus
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h40; waitrequest = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_read_before", {31'b0, read}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_read_drop", {31'b0, read}, 32'd0);
    chk("mid_write", {31'b0, write}, 32'd0);
    chk("mid_be", {28'b0, byteenable}, 32'd0);
    chk("mid_addr", address, 32'd0);
    chk("mid_ready_low", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    waitrequest = 1'b0;
    #1 chk("mid_ready_rel", {31'b0, req_ready}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("mid_noresp%0d", c), {31'b0, resp_valid}, 32'd0);
    end

    run_vec(vecs[4], 99);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
